mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter MEM_WORDS, default 256, the number of 32-bit words in the attached memory (power of two).
REQ-002 SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit, an asynchronous active-low reset.
REQ-004 SHALL have port if_req_valid, input, 1 bit, an instruction-fetch read request.
REQ-005 SHALL have port if_req_addr, input, 32 bits, the fetch byte address.
REQ-006 SHALL have port if_req_ready, output, 1 bit, fetch request accepted this cycle.
REQ-007 SHALL have port if_resp_valid, output, 1 bit, fetch response present.
REQ-008 SHALL have port if_resp_rdata, output, 32 bits, fetch read data.
REQ-009 SHALL have port if_resp_err, output, 1 bit, fetch access fault.
REQ-010 SHALL have port d_req_valid, input, 1 bit, a load/store request.
REQ-011 SHALL have port d_req_we, input, 1 bit: 1 = store, 0 = load.
REQ-012 SHALL have port d_req_addr, input, 32 bits, the data byte address.
REQ-013 SHALL have port d_req_wdata, input, 32 bits, the store data.
REQ-014 SHALL have port d_req_ready, output, 1 bit, data request accepted this cycle.
REQ-015 SHALL have ports d_resp_valid, d_resp_rdata and d_resp_err, outputs of 1, 32 and 1 bits, the data response (same meanings as the fetch response).
REQ-016 SHALL have port mem_write_enable, output, 1 bit, the memory write strobe.
REQ-017 SHALL have port mem_addr, output, 32 bits, the memory byte address; the memory indexes words with addr[31:2].
REQ-018 SHALL have port mem_wdata, output, 32 bits, data the top level drives onto the memory bus while mem_write_enable=1.
REQ-019 SHALL have port mem_rdata, input, 32 bits, the memory registered read data, valid one cycle after the address is presented.

Function
REQ-020 SHALL accept at most one request per cycle; a request is accepted when valid && ready are both high at a rising clk edge.
REQ-021 SHALL derive if_req_ready and d_req_ready combinationally; at most one is high in any cycle; a ready is never high unless its valid is high.
REQ-022 SHALL arbitrate with a 1-bit round-robin pointer last_grant: if only one valid is high, grant that requester; if both are high, grant the requester not in last_grant.
REQ-023 SHALL update last_grant to the granted requester on every accepted request and otherwise hold it.
REQ-024 SHALL drive mem_addr, mem_wdata and mem_write_enable combinationally from the granted request; with no grant it SHALL drive mem_write_enable=0 and hold mem_addr at 0.
REQ-025 SHALL flag an access fault when addr[1:0]!=0 (misaligned) or addr[31:2] >= MEM_WORDS (out of range).
REQ-026 SHALL force mem_write_enable=0 on a faulting store; the memory is never written on a fault.
REQ-027 SHALL assert exactly one response one cycle after acceptance: *_resp_valid for exactly one cycle, on the port of the accepted requester.
REQ-028 SHALL have no response backpressure; requesters always accept responses.
REQ-029 SHALL, for a good load or fetch, drive resp_rdata = mem_rdata and resp_err=0.
REQ-030 SHALL, for a store, drive resp_rdata=0 and resp_err=0 (the store acknowledge).
REQ-031 SHALL, for a fault, drive resp_rdata=0 and resp_err=1.
REQ-032 SHALL drive all resp_rdata and resp_err to 0 whenever the matching resp_valid is 0.
REQ-033 SHALL sustain full throughput: a new grant in the same cycle as the previous response, giving one access per cycle back-to-back.
REQ-034 SHALL register per-cycle response state: resp_pending, resp_port, resp_kind (read, store, fault).

Reset
REQ-035 SHALL, while rst_n=0, clear resp_pending, set last_grant=fetch (data wins the first contention), and hold every output at 0, including both readys.
REQ-036 SHALL, on reset asserted with a response in flight, drop that response; no resp_valid appears after reset release.
REQ-037 SHALL accept requests on the first rising edge after rst_n deasserts.

Verification
REQ-038 SHALL cover: after reset, both valid, if_addr=0x10, d load 0x20 -> data granted first, d_resp next cycle with mem[8]; fetch granted the following cycle.
REQ-039 SHALL cover: both valid continuously for 6 cycles -> grants alternate D,I,D,I,D,I with one response per cycle.
REQ-040 SHALL cover: store 0xDEADBEEF to 0x40, then fetch 0x40 -> store ack with rdata=0; fetch rdata=0xDEADBEEF.
REQ-041 SHALL cover: store to 0x42 and load from 0x400 (MEM_WORDS=256) -> err=1, rdata=0, mem_write_enable never high, mem[16] unchanged.
REQ-042 SHALL cover: rst_n pulsed low the cycle after a fetch is accepted -> no if_resp_valid; outputs 0 during reset; a fetch on the first post-reset edge responds normally.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Two-requester arbiter in front of a single-port word memory. The
//   instruction-fetch port (read only) and the data port (load/store) compete
//   for one access per cycle under a 1-bit round-robin pointer. The request
//   is forwarded combinationally to the memory. A response comes back on the
//   winner's port exactly one cycle later, carrying the memory's registered
//   read data, a store acknowledge, or an access fault.
//
// Ports
//   clk, rst_n                     clock, asynchronous active-low reset
//   if_req_valid/addr/ready        fetch request handshake
//   if_resp_valid/rdata/err        fetch response (one cycle, no backpressure)
//   d_req_valid/we/addr/wdata/ready  data request handshake
//   d_resp_valid/rdata/err         data response (one cycle, no backpressure)
//   mem_write_enable/addr/wdata    memory request, driven from the grant
//   mem_rdata                      memory read data, registered one cycle
//                                  after the address
module mem_arbiter #(
  parameter int MEM_WORDS = 256
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_req_valid,
  input  logic [31:0] if_req_addr,
  output logic        if_req_ready,
  output logic        if_resp_valid,
  output logic [31:0] if_resp_rdata,
  output logic        if_resp_err,
  input  logic        d_req_valid,
  input  logic        d_req_we,
  input  logic [31:0] d_req_addr,
  input  logic [31:0] d_req_wdata,
  output logic        d_req_ready,
  output logic        d_resp_valid,
  output logic [31:0] d_resp_rdata,
  output logic        d_resp_err,
  output logic        mem_write_enable,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {
    KIND_READ  = 2'd0,
    KIND_STORE = 2'd1,
    KIND_FAULT = 2'd2
  } kind_e;

  localparam logic PORT_IF = 1'b0;
  localparam logic PORT_D  = 1'b1;

  // Misaligned or beyond the end of the attached memory.
  function automatic logic addr_fault(input logic [31:0] a);
    return (a[1:0] != 2'b00) || ({2'b00, a[31:2]} >= 32'(MEM_WORDS));
  endfunction

  logic        last_grant;
  logic        resp_pending;
  logic        resp_port;
  kind_e       resp_kind;

  logic        grant_i;
  logic        grant_d;
  logic        g_we;
  logic        g_fault;
  logic [31:0] g_addr;
  logic [31:0] g_wdata;

  // Request side: arbitration and memory drive, all combinational. Gated by
  // rst_n so every output (readys included) is 0 while reset is held.
  always_comb begin
    grant_i = 1'b0;
    grant_d = 1'b0;
    g_we    = 1'b0;
    g_fault = 1'b0;
    g_addr  = 32'd0;
    g_wdata = 32'd0;
    if (rst_n) begin
      // Data wins when alone, or when both ask and fetch won last time.
      if (d_req_valid && (!if_req_valid || last_grant == PORT_IF)) begin
        grant_d = 1'b1;
      end else if (if_req_valid) begin
        grant_i = 1'b1;
      end
    end
    if (grant_d) begin
      g_addr  = d_req_addr;
      g_we    = d_req_we;
      g_wdata = d_req_we ? d_req_wdata : 32'd0;
    end else if (grant_i) begin
      g_addr  = if_req_addr;
    end
    if (grant_i || grant_d) begin
      g_fault = addr_fault(g_addr);
    end
  end

  assign if_req_ready     = grant_i;
  assign d_req_ready      = grant_d;
  assign mem_addr         = g_addr;
  assign mem_wdata        = g_wdata;
  assign mem_write_enable = g_we && !g_fault;

  // Response state: one response per accepted request, one cycle later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant   <= PORT_IF;
      resp_pending <= 1'b0;
      resp_port    <= PORT_IF;
      resp_kind    <= KIND_READ;
    end else begin
      resp_pending <= grant_i || grant_d;
      if (grant_i || grant_d) begin
        last_grant <= grant_d ? PORT_D : PORT_IF;
        resp_port  <= grant_d ? PORT_D : PORT_IF;
        if (g_fault) begin
          resp_kind <= KIND_FAULT;
        end else if (g_we) begin
          resp_kind <= KIND_STORE;
        end else begin
          resp_kind <= KIND_READ;
        end
      end
    end
  end

  logic [31:0] resp_rdata;
  logic        resp_err;

  // Only a good read returns memory data; stores and faults return zero.
  assign resp_rdata = (resp_kind == KIND_READ) ? mem_rdata : 32'd0;
  assign resp_err   = (resp_kind == KIND_FAULT);

  assign if_resp_valid = resp_pending && (resp_port == PORT_IF);
  assign d_resp_valid  = resp_pending && (resp_port == PORT_D);
  assign if_resp_rdata = if_resp_valid ? resp_rdata : 32'd0;
  assign if_resp_err   = if_resp_valid && resp_err;
  assign d_resp_rdata  = d_resp_valid ? resp_rdata : 32'd0;
  assign d_resp_err    = d_resp_valid && resp_err;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed testbench for mem_arbiter with a 256-word registered-read memory.
module tb_mem_arbiter;

  logic        clk;
  logic        rst_n;
  logic        if_req_valid;
  logic [31:0] if_req_addr;
  logic        if_req_ready;
  logic        if_resp_valid;
  logic [31:0] if_resp_rdata;
  logic        if_resp_err;
  logic        d_req_valid;
  logic        d_req_we;
  logic [31:0] d_req_addr;
  logic [31:0] d_req_wdata;
  logic        d_req_ready;
  logic        d_resp_valid;
  logic [31:0] d_resp_rdata;
  logic        d_resp_err;
  logic        mem_write_enable;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] mem [256];
  logic        fault_win;
  logic        we_seen;

  mem_arbiter #(.MEM_WORDS(256)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .if_req_valid    (if_req_valid),
    .if_req_addr     (if_req_addr),
    .if_req_ready    (if_req_ready),
    .if_resp_valid   (if_resp_valid),
    .if_resp_rdata   (if_resp_rdata),
    .if_resp_err     (if_resp_err),
    .d_req_valid     (d_req_valid),
    .d_req_we        (d_req_we),
    .d_req_addr      (d_req_addr),
    .d_req_wdata     (d_req_wdata),
    .d_req_ready     (d_req_ready),
    .d_resp_valid    (d_resp_valid),
    .d_resp_rdata    (d_resp_rdata),
    .d_resp_err      (d_resp_err),
    .mem_write_enable(mem_write_enable),
    .mem_addr        (mem_addr),
    .mem_wdata       (mem_wdata),
    .mem_rdata       (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: registered read, write on strobe.
  always @(posedge clk) begin
    if (mem_write_enable) mem[mem_addr[9:2]] <= mem_wdata;
    mem_rdata <= mem[mem_addr[9:2]];
  end

  always @(posedge clk) begin
    if (fault_win && mem_write_enable) we_seen <= 1'b1;
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout got=running required=finished");
    $fatal(1, "timeout");
  end

  task automatic idle();
    if_req_valid = 1'b0;
    if_req_addr  = 32'd0;
    d_req_valid  = 1'b0;
    d_req_we     = 1'b0;
    d_req_addr   = 32'd0;
    d_req_wdata  = 32'd0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    if_req_valid = 1'b1; if_req_addr = 32'h10;
    d_req_valid = 1'b1; d_req_we = 1'b1; d_req_addr = 32'h40; d_req_wdata = 32'h1234_5678;
    @(negedge clk); #1;
    n_tests++;
    if (if_req_ready !== 1'b0 || d_req_ready !== 1'b0) begin
      n_fail++; $display("FAIL reset_readys got=%b%b required=00", if_req_ready, d_req_ready);
    end
    n_tests++;
    if (mem_write_enable !== 1'b0 || mem_addr !== 32'd0 || mem_wdata !== 32'd0) begin
      n_fail++; $display("FAIL reset_mem got we=%b addr=%h wdata=%h required=0", mem_write_enable, mem_addr, mem_wdata);
    end
    @(posedge clk); #1;
    n_tests++;
    if (if_resp_valid !== 1'b0 || d_resp_valid !== 1'b0 || if_resp_rdata !== 32'd0 ||
        d_resp_rdata !== 32'd0 || if_resp_err !== 1'b0 || d_resp_err !== 1'b0) begin
      n_fail++; $display("FAIL reset_resp got iv=%b dv=%b required=0", if_resp_valid, d_resp_valid);
    end
    @(negedge clk);
    idle();
    rst_n = 1'b1;
  endtask

  task automatic test_contention();
    @(negedge clk);
    if_req_valid = 1'b1; if_req_addr = 32'h10;
    d_req_valid = 1'b1; d_req_we = 1'b0; d_req_addr = 32'h20;
    #1;
    n_tests++;
    if (d_req_ready !== 1'b1 || if_req_ready !== 1'b0 || mem_addr !== 32'h20) begin
      n_fail++; $display("FAIL first_grant got d=%b i=%b addr=%h required d=1 i=0 addr=20", d_req_ready, if_req_ready, mem_addr);
    end
    @(posedge clk); #1;
    n_tests++;
    if (d_resp_valid !== 1'b1 || d_resp_rdata !== 32'hA000_0008 || d_resp_err !== 1'b0 || if_resp_valid !== 1'b0) begin
      n_fail++; $display("FAIL d_load_resp got v=%b data=%h required v=1 data=a0000008", d_resp_valid, d_resp_rdata);
    end
    @(negedge clk);
    d_req_valid = 1'b0;
    #1;
    n_tests++;
    if (if_req_ready !== 1'b1 || d_req_ready !== 1'b0 || mem_addr !== 32'h10) begin
      n_fail++; $display("FAIL second_grant got i=%b addr=%h required i=1 addr=10", if_req_ready, mem_addr);
    end
    @(posedge clk); #1;
    n_tests++;
    if (if_resp_valid !== 1'b1 || if_resp_rdata !== 32'hA000_0004 || d_resp_valid !== 1'b0) begin
      n_fail++; $display("FAIL fetch_resp got v=%b data=%h required v=1 data=a0000004", if_resp_valid, if_resp_rdata);
    end
    @(negedge clk);
    idle();
    @(posedge clk); #1;
    n_tests++;
    if (if_resp_valid !== 1'b0 || d_resp_valid !== 1'b0) begin
      n_fail++; $display("FAIL idle_no_resp got iv=%b dv=%b required 0", if_resp_valid, d_resp_valid);
    end
  endtask

  task automatic test_back_to_back();
    logic exp_d;
    @(negedge clk);
    if_req_valid = 1'b1; if_req_addr = 32'h14;
    d_req_valid = 1'b1; d_req_we = 1'b0; d_req_addr = 32'h30;
    for (int k = 0; k < 6; k++) begin
      exp_d = (k % 2 == 0);
      #1;
      n_tests++;
      if (d_req_ready !== exp_d || if_req_ready !== !exp_d) begin
        n_fail++; $display("FAIL alt_grant%0d got d=%b i=%b required d=%b", k, d_req_ready, if_req_ready, exp_d);
      end
      @(posedge clk); #1;
      n_tests++;
      if (exp_d) begin
        if (d_resp_valid !== 1'b1 || if_resp_valid !== 1'b0 || d_resp_rdata !== 32'hA000_000C) begin
          n_fail++; $display("FAIL alt_resp%0d got dv=%b iv=%b data=%h required dv=1 data=a000000c", k, d_resp_valid, if_resp_valid, d_resp_rdata);
        end
      end else begin
        if (if_resp_valid !== 1'b1 || d_resp_valid !== 1'b0 || if_resp_rdata !== 32'hA000_0005) begin
          n_fail++; $display("FAIL alt_resp%0d got iv=%b dv=%b data=%h required iv=1 data=a0000005", k, if_resp_valid, d_resp_valid, if_resp_rdata);
        end
      end
      @(negedge clk);
    end
    idle();
  endtask

  task automatic test_store_fetch();
    @(negedge clk);
    d_req_valid = 1'b1; d_req_we = 1'b1; d_req_addr = 32'h40; d_req_wdata = 32'hDEAD_BEEF;
    #1;
    n_tests++;
    if (d_req_ready !== 1'b1 || mem_write_enable !== 1'b1 || mem_wdata !== 32'hDEAD_BEEF || mem_addr !== 32'h40) begin
      n_fail++; $display("FAIL store_drive got rdy=%b we=%b wdata=%h required 1 1 deadbeef", d_req_ready, mem_write_enable, mem_wdata);
    end
    @(posedge clk); #1;
    n_tests++;
    if (d_resp_valid !== 1'b1 || d_resp_rdata !== 32'd0 || d_resp_err !== 1'b0) begin
      n_fail++; $display("FAIL store_ack got v=%b data=%h err=%b required 1 0 0", d_resp_valid, d_resp_rdata, d_resp_err);
    end
    @(negedge clk);
    idle();
    if_req_valid = 1'b1; if_req_addr = 32'h40;
    #1;
    n_tests++;
    if (if_req_ready !== 1'b1 || mem_write_enable !== 1'b0) begin
      n_fail++; $display("FAIL fetch40_grant got rdy=%b we=%b required 1 0", if_req_ready, mem_write_enable);
    end
    @(posedge clk); #1;
    n_tests++;
    if (if_resp_valid !== 1'b1 || if_resp_rdata !== 32'hDEAD_BEEF || if_resp_err !== 1'b0) begin
      n_fail++; $display("FAIL fetch40_data got v=%b data=%h required 1 deadbeef", if_resp_valid, if_resp_rdata);
    end
    @(negedge clk);
    idle();
  endtask

  task automatic test_faults();
    fault_win = 1'b1;
    @(negedge clk);
    d_req_valid = 1'b1; d_req_we = 1'b1; d_req_addr = 32'h42; d_req_wdata = 32'h1234_5678;
    #1;
    n_tests++;
    if (d_req_ready !== 1'b1 || mem_write_enable !== 1'b0) begin
      n_fail++; $display("FAIL mis_store_drive got rdy=%b we=%b required 1 0", d_req_ready, mem_write_enable);
    end
    @(posedge clk); #1;
    n_tests++;
    if (d_resp_valid !== 1'b1 || d_resp_err !== 1'b1 || d_resp_rdata !== 32'd0) begin
      n_fail++; $display("FAIL mis_store_resp got v=%b err=%b data=%h required 1 1 0", d_resp_valid, d_resp_err, d_resp_rdata);
    end
    @(negedge clk);
    d_req_we = 1'b0; d_req_addr = 32'h400; d_req_wdata = 32'd0;
    @(posedge clk); #1;
    n_tests++;
    if (d_resp_valid !== 1'b1 || d_resp_err !== 1'b1 || d_resp_rdata !== 32'd0) begin
      n_fail++; $display("FAIL oor_load_resp got v=%b err=%b data=%h required 1 1 0", d_resp_valid, d_resp_err, d_resp_rdata);
    end
    @(negedge clk);
    idle();
    if_req_valid = 1'b1; if_req_addr = 32'h401;
    @(posedge clk); #1;
    n_tests++;
    if (if_resp_valid !== 1'b1 || if_resp_err !== 1'b1 || if_resp_rdata !== 32'd0) begin
      n_fail++; $display("FAIL bad_fetch_resp got v=%b err=%b data=%h required 1 1 0", if_resp_valid, if_resp_err, if_resp_rdata);
    end
    @(negedge clk);
    idle();
    fault_win = 1'b0;
    n_tests++;
    if (we_seen !== 1'b0 || mem[16] !== 32'hDEAD_BEEF) begin
      n_fail++; $display("FAIL fault_no_write got we_seen=%b mem16=%h required 0 deadbeef", we_seen, mem[16]);
    end
  endtask

  task automatic test_reset_inflight();
    @(negedge clk);
    if_req_valid = 1'b1; if_req_addr = 32'h8;
    @(posedge clk); #1;
    rst_n = 1'b0;
    d_req_valid = 1'b1; d_req_addr = 32'h20;
    #1;
    n_tests++;
    if (if_resp_valid !== 1'b0 || if_resp_rdata !== 32'd0 || if_req_ready !== 1'b0 || d_req_ready !== 1'b0 || mem_addr !== 32'd0) begin
      n_fail++; $display("FAIL inflight_reset got iv=%b ir=%b dr=%b addr=%h required 0", if_resp_valid, if_req_ready, d_req_ready, mem_addr);
    end
    @(posedge clk); #1;
    n_tests++;
    if (if_resp_valid !== 1'b0 || d_resp_valid !== 1'b0) begin
      n_fail++; $display("FAIL inflight_dropped got iv=%b dv=%b required 0", if_resp_valid, d_resp_valid);
    end
    @(negedge clk);
    d_req_valid = 1'b0; d_req_addr = 32'd0;
    if_req_valid = 1'b1; if_req_addr = 32'h8;
    rst_n = 1'b1;
    #1;
    n_tests++;
    if (if_req_ready !== 1'b1) begin
      n_fail++; $display("FAIL post_reset_ready got %b required 1", if_req_ready);
    end
    @(posedge clk); #1;
    n_tests++;
    if (if_resp_valid !== 1'b1 || if_resp_rdata !== 32'hA000_0002 || if_resp_err !== 1'b0) begin
      n_fail++; $display("FAIL post_reset_fetch got v=%b data=%h required 1 a0000002", if_resp_valid, if_resp_rdata);
    end
    @(negedge clk);
    idle();
    @(posedge clk); #1;
    n_tests++;
    if (if_resp_valid !== 1'b0) begin
      n_fail++; $display("FAIL post_reset_single got %b required 0", if_resp_valid);
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'hA000_0000 + i;
    mem_rdata = 32'd0;
    fault_win = 1'b0;
    we_seen   = 1'b0;
    idle();
    test_reset();
    test_contention();
    test_back_to_back();
    test_store_fetch();
    test_faults();
    test_reset_inflight();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
